// File: rtl/risc_v_mike_gpio_ctrl.sv
// MMIO GPIO controller: per-pin direction, atomic set/clear/toggle of OUT,
// synchronised inputs with armed edge detection and sticky W1C interrupt status.
module risc_v_mike_gpio_ctrl #(
  parameter int          GPIO_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_mmio_wr_en,
  input  logic              data_mmio_rd_en,
  input  logic [31:0]       data_mmio_addr,
  input  logic [31:0]       data_mmio_wr_data,
  output logic [31:0]       data_mmio_rd_data,
  input  logic [GPIO_W-1:0] gpio_port_in,
  output logic [GPIO_W-1:0] gpio_port_out,
  output logic [GPIO_W-1:0] gpio_port_oe,
  output logic              gpio_irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);

  function automatic logic [31:0] widen(input logic [GPIO_W-1:0] v);
    widen = '0;
    widen[GPIO_W-1:0] = v;
  endfunction

  logic [31:0]       offset;
  logic              hit;
  logic [3:0]        reg_idx;
  logic              wr_hit;
  logic [GPIO_W-1:0] wd;
  logic              unused_bits;

  logic [GPIO_W-1:0] out_q, dir_q, rise_en_q, fall_en_q, stat_q;
  logic [GPIO_W-1:0] out_next, stat_next, w1c_mask;
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] in_val, in_prev, rise, fall;
  logic [CNT_W-1:0]  arm_cnt;
  logic              armed;

  assign offset      = data_mmio_addr - BASE_ADDR;
  assign hit         = (offset <= 32'h20) && (offset[1:0] == 2'b00);
  assign reg_idx     = offset[5:2];
  assign wr_hit      = data_mmio_wr_en && hit;
  assign wd          = data_mmio_wr_data[GPIO_W-1:0];
  assign unused_bits = ^{data_mmio_wr_data, offset};

  // Input synchroniser chain followed by the previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= gpio_port_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_val = sync_q[SYNC_STAGES-1];

  // Masks edges until the chain and in_prev hold real pin data after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt <= CNT_W'(SYNC_STAGES + 1);
    end else if (arm_cnt != '0) begin
      arm_cnt <= arm_cnt - 1'b1;
    end
  end

  assign armed = (arm_cnt == '0);
  assign rise  = armed ? (in_val & ~in_prev) : '0;
  assign fall  = armed ? (~in_val & in_prev) : '0;

  always_comb begin
    out_next = out_q;
    w1c_mask = '0;
    if (wr_hit) begin
      case (reg_idx)
        4'd0:    out_next = wd;
        4'd3:    out_next = out_q | wd;
        4'd4:    out_next = out_q & ~wd;
        4'd5:    out_next = out_q ^ wd;
        4'd8:    w1c_mask = wd;
        default: ;
      endcase
    end
    // New edges are ORed in last so they win over a simultaneous W1C
    stat_next = (stat_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
    end else begin
      out_q  <= out_next;
      stat_q <= stat_next;
      if (wr_hit && reg_idx == 4'd2) dir_q     <= wd;
      if (wr_hit && reg_idx == 4'd6) rise_en_q <= wd;
      if (wr_hit && reg_idx == 4'd7) fall_en_q <= wd;
    end
  end

  always_comb begin
    data_mmio_rd_data = '0;
    if (data_mmio_rd_en && hit) begin
      case (reg_idx)
        4'd0:    data_mmio_rd_data = widen(out_q);
        4'd1:    data_mmio_rd_data = widen(in_val);
        4'd2:    data_mmio_rd_data = widen(dir_q);
        4'd6:    data_mmio_rd_data = widen(rise_en_q);
        4'd7:    data_mmio_rd_data = widen(fall_en_q);
        4'd8:    data_mmio_rd_data = widen(stat_q);
        default: data_mmio_rd_data = '0;
      endcase
    end
  end

  assign gpio_port_out = out_q;
  assign gpio_port_oe  = dir_q;
  assign gpio_irq      = |stat_q;

endmodule

// File: tb/tb_risc_v_mike_gpio_ctrl.sv
// Scoreboard bench for risc_v_mike_gpio_ctrl: stimulus queues expected values,
// a negedge monitor pops and compares them against the selected DUT output.
module tb_risc_v_mike_gpio_ctrl;

  localparam int K_RD = 0, K_OUT = 1, K_OE = 2, K_IRQ = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] addr, wr_data, rd_data;
  logic [7:0]  pin_in, pin_out, pin_oe;
  logic        irq;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } chk_t;

  chk_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  risc_v_mike_gpio_ctrl #(.GPIO_W(8), .SYNC_STAGES(2), .BASE_ADDR(32'h0)) dut (
    .clk               (clk),
    .rst               (rst),
    .data_mmio_wr_en   (wr_en),
    .data_mmio_rd_en   (rd_en),
    .data_mmio_addr    (addr),
    .data_mmio_wr_data (wr_data),
    .data_mmio_rd_data (rd_data),
    .gpio_port_in      (pin_in),
    .gpio_port_out     (pin_out),
    .gpio_port_oe      (pin_oe),
    .gpio_irq          (irq)
  );

  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the live DUT output
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.kind)
        K_RD:    act = rd_data;
        K_OUT:   act = {24'h0, pin_out};
        K_OE:    act = {24'h0, pin_oe};
        default: act = {31'h0, irq};
      endcase
      n_total++;
      if (act === c.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.val);
    end
  end

  task automatic push(input int kind, input string name, input logic [31:0] val);
    chk_t c;
    c.name = name; c.kind = kind; c.val = val;
    q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Write to an OUT-modifying register; OUT must hold before the edge and change after
  task automatic wr_out(input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] old_v, input logic [7:0] new_v, input string name);
    wr_en = 1'b1; addr = a; wr_data = d;
    push(K_OUT, {name, "_before"}, {24'h0, old_v});
    @(posedge clk); #1;
    wr_en = 1'b0;
    push(K_OUT, name, {24'h0, new_v});
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp_v, input string name);
    rd_en = 1'b1; addr = a;
    push(K_RD, name, exp_v);
    @(negedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic out_chk(input int kind, input logic [31:0] exp_v, input string name);
    push(kind, name, exp_v);
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0; pin_in = 8'h00;
    tick(2);
    rst = 1'b0;
    out_chk(K_OUT, 0, "reset_out");
    out_chk(K_OE,  0, "reset_oe");
    out_chk(K_IRQ, 0, "reset_irq");
    rd_chk(32'h00, 0, "reset_rd_out");

    // Basic OUT / DIR writes and decode misses
    wr_out(32'h00, 32'hA5, 8'h00, 8'hA5, "out_a5");
    wr(32'h08, 32'h0F);
    out_chk(K_OE, 32'h0F, "oe_0f");
    rd_chk(32'h00, 32'h000000A5, "rd_out_a5");
    rd_chk(32'h08, 32'h0000000F, "rd_dir_0f");
    rd_chk(32'h24, 0, "rd_miss_24");
    rd_chk(32'h02, 0, "rd_unaligned");
    rd_chk(32'h0C, 0, "rd_wo_set");

    // Atomic set / clear / toggle
    wr_out(32'h00, 32'hF0, 8'hA5, 8'hF0, "out_f0");
    wr_out(32'h0C, 32'h03, 8'hF0, 8'hF3, "set_03");
    wr_out(32'h10, 32'h30, 8'hF3, 8'hC3, "clr_30");
    wr_out(32'h14, 32'hFF, 8'hC3, 8'h3C, "tgl_ff");
    wr_out(32'h00, 32'hFFFFFF5A, 8'h3C, 8'h5A, "out_wide");
    rd_chk(32'h00, 32'h0000005A, "rd_out_upper_zero");

    // Simultaneous read and write returns the pre-write value
    rd_en = 1'b1; wr_en = 1'b1; addr = 32'h00; wr_data = 32'h11;
    push(K_RD, "rdwr_pre", 32'h5A);
    @(negedge clk); #1;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    rd_chk(32'h00, 32'h11, "rdwr_post");
    addr = 32'h00;
    out_chk(K_RD, 0, "rd_en_low");

    // Input synchroniser latency
    rd_en = 1'b1; addr = 32'h04;
    pin_in = 8'h81;
    push(K_RD, "in_lat0", 0);
    @(posedge clk); #1;
    push(K_RD, "in_lat1", 0);
    @(posedge clk); #1;
    push(K_RD, "in_lat2", 32'h81);
    @(negedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;

    // Edge detection, sticky status and W1C
    pin_in = 8'h80;
    tick(4);
    wr(32'h18, 32'h01);
    wr(32'h1C, 32'h80);
    wr(32'h20, 32'hFF);
    rd_chk(32'h18, 32'h01, "rd_rise_en");
    rd_chk(32'h20, 0, "stat_clear");
    pin_in = 8'h01;
    tick(5);
    rd_chk(32'h20, 32'h81, "stat_81");
    out_chk(K_IRQ, 1, "irq_set");
    wr(32'h20, 32'h01);
    tick(1);
    rd_chk(32'h20, 32'h80, "stat_w1c_bit0");
    out_chk(K_IRQ, 1, "irq_still");
    wr(32'h20, 32'h80);
    tick(2);
    rd_chk(32'h20, 0, "stat_w1c_bit7");
    out_chk(K_IRQ, 0, "irq_drop");

    // Pin held high through reset must not produce a rise
    pin_in = 8'h01;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wr(32'h18, 32'h01);
    tick(6);
    rd_chk(32'h20, 0, "no_false_rise");
    pin_in = 8'h00;
    tick(4);
    pin_in = 8'h01;
    tick(5);
    rd_chk(32'h20, 32'h01, "rise_after_arm");

    // W1C in the same cycle as a new rise: set wins
    pin_in = 8'h00;
    tick(4);
    pin_in = 8'h01;
    tick(2);
    wr(32'h20, 32'h01);
    tick(1);
    rd_chk(32'h20, 32'h01, "set_beats_w1c");
    wr(32'h20, 32'h01);
    rd_chk(32'h20, 0, "w1c_alone");

    // Asynchronous reset mid-operation
    wr(32'h00, 32'hAA);
    wr(32'h08, 32'hFF);
    pin_in = 8'h00;
    tick(4);
    pin_in = 8'h01;
    tick(5);
    out_chk(K_IRQ, 1, "irq_before_rst");
    #1;
    push(K_OUT, "out_before_rst", 32'hAA);
    push(K_OE,  "oe_before_rst",  32'hFF);
    @(negedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    push(K_OUT, "async_rst_out", 0);
    push(K_OE,  "async_rst_oe",  0);
    push(K_IRQ, "async_rst_irq", 0);
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);
    rd_chk(32'h18, 0, "rst_rise_en");

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
